// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low segment constants {g,f,e,d,c,b,a}
// (common with the hex encoder) and the collector state type.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } seg7_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the hex-to-7-segment encoder: exact-match lookup,
// blank and unrecognised patterns flagged with a zero nibble.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_nibble,
    output logic       o_blank,
    output logic       o_err
);

    // Exact pattern match; anything outside the table is an error
    always_comb begin
        o_nibble = 4'h0;
        o_blank  = 1'b0;
        o_err    = 1'b0;
        case (i_seg)
            SEG_0:     o_nibble = 4'h0;
            SEG_1:     o_nibble = 4'h1;
            SEG_2:     o_nibble = 4'h2;
            SEG_3:     o_nibble = 4'h3;
            SEG_4:     o_nibble = 4'h4;
            SEG_5:     o_nibble = 4'h5;
            SEG_6:     o_nibble = 4'h6;
            SEG_7:     o_nibble = 4'h7;
            SEG_8:     o_nibble = 4'h8;
            SEG_9:     o_nibble = 4'h9;
            SEG_A:     o_nibble = 4'hA;
            SEG_B:     o_nibble = 4'hB;
            SEG_C:     o_nibble = 4'hC;
            SEG_D:     o_nibble = 4'hD;
            SEG_E:     o_nibble = 4'hE;
            SEG_F:     o_nibble = 4'hF;
            SEG_BLANK: o_blank  = 1'b1;
            default:   o_err    = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_decode_collect.sv
// Collects NUM_DIGITS decoded 7-segment digits into one word (first digit in MS nibble).
// SEG7_BACKTOBACK_EN: lets a digit be accepted in the same cycle as the word handshake.
module seg7_decode_collect
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [6:0]              seg_in,
    input  logic                    seg_valid,
    output logic                    seg_ready,
    output logic [4*NUM_DIGITS-1:0] word_out,
    output logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [NUM_DIGITS-1:0]   err_mask,
    output logic                    word_valid,
    input  logic                    word_ready
);

    localparam int         LP_W  = 4 * NUM_DIGITS;
    localparam logic [3:0] LP_ND = 4'(NUM_DIGITS);

    seg7_state_t           r_state;
    logic [3:0]            r_count;
    logic [LP_W-1:0]       r_word;
    logic [NUM_DIGITS-1:0] r_blank;
    logic [NUM_DIGITS-1:0] r_err;
    logic                  r_live;

    seg7_state_t           w_state_nxt;
    logic [3:0]            w_count_nxt;
    logic [LP_W-1:0]       w_word_nxt;
    logic [NUM_DIGITS-1:0] w_blank_nxt;
    logic [NUM_DIGITS-1:0] w_err_nxt;
    logic [3:0]            w_nib;
    logic                  w_is_blank;
    logic                  w_is_err;
    logic                  w_ready;
    logic                  w_hs;
    logic                  w_acc;
    logic [3:0]            w_base;
    logic [3:0]            w_count_inc;

    seg7_pattern_decode u_decode (
        .i_seg    (seg_in),
        .o_nibble (w_nib),
        .o_blank  (w_is_blank),
        .o_err    (w_is_err)
    );

    // Input readiness: open in COLLECT once out of reset; in HOLD only when back-to-back is built in
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            COLLECT: w_ready = r_live;
`ifdef SEG7_BACKTOBACK_EN
            HOLD:    w_ready = r_live & word_ready;
`else
            HOLD:    w_ready = 1'b0;
`endif
            default: w_ready = 1'b0;
        endcase
    end

    assign seg_ready   = w_ready;
    assign word_valid  = (r_state == HOLD);
    assign word_out    = r_word;
    assign blank_mask  = r_blank;
    assign err_mask    = r_err;

    assign w_hs        = (r_state == HOLD) & word_ready;
    assign w_acc       = seg_valid & w_ready;
    // A digit taken alongside the handshake starts a fresh word
    assign w_base      = w_hs ? 4'd0 : r_count;
    assign w_count_inc = w_base + 4'd1;

    // Next-state: handshake releases the word, an accepted digit shifts in at the LS end
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_word_nxt  = r_word;
        w_blank_nxt = r_blank;
        w_err_nxt   = r_err;
        if (w_hs) begin
            w_state_nxt = COLLECT;
            w_count_nxt = 4'd0;
        end else begin
            w_state_nxt = r_state;
        end
        if (w_acc) begin
            w_word_nxt = (r_word << 4) | LP_W'(w_nib);
            if (w_base == 4'd0) begin
                w_blank_nxt = NUM_DIGITS'(w_is_blank);
                w_err_nxt   = NUM_DIGITS'(w_is_err);
            end else begin
                w_blank_nxt = (r_blank << 1) | NUM_DIGITS'(w_is_blank);
                w_err_nxt   = (r_err << 1) | NUM_DIGITS'(w_is_err);
            end
            if (w_count_inc == LP_ND) begin
                w_state_nxt = HOLD;
                w_count_nxt = 4'd0;
            end else begin
                w_state_nxt = COLLECT;
                w_count_nxt = w_count_inc;
            end
        end else begin
            w_word_nxt = r_word;
        end
    end

    // State registers; clear flushes the partial word but keeps word_out
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= COLLECT;
            r_count <= 4'd0;
            r_word  <= '0;
            r_blank <= '0;
            r_err   <= '0;
            r_live  <= 1'b0;
        end else if (clear) begin
            r_state <= COLLECT;
            r_count <= 4'd0;
            r_blank <= '0;
            r_err   <= '0;
            r_live  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_word  <= w_word_nxt;
            r_blank <= w_blank_nxt;
            r_err   <= w_err_nxt;
            r_live  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seg7_decode_collect.sv
// Randomised and directed bench for seg7_decode_collect against a digit-queue reference model.
module tb_seg7_decode_collect;

    localparam int N = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic [6:0]    seg_in;
    logic          seg_valid;
    logic          seg_ready;
    logic [4*N-1:0] word_out;
    logic [N-1:0]  blank_mask;
    logic [N-1:0]  err_mask;
    logic          word_valid;
    logic          word_ready;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] ref_pat [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // reference model: pending digits plus the word currently presented
    int         q_nib [$];
    bit         q_blk [$];
    bit         q_err [$];
    bit         m_live;
    bit         m_hold;
    logic [4*N-1:0] m_word;
    logic [N-1:0]   m_blank;
    logic [N-1:0]   m_err;
    logic       obs_ready;

    seg7_decode_collect #(.NUM_DIGITS(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .seg_in     (seg_in),
        .seg_valid  (seg_valid),
        .seg_ready  (seg_ready),
        .word_out   (word_out),
        .blank_mask (blank_mask),
        .err_mask   (err_mask),
        .word_valid (word_valid),
        .word_ready (word_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ref_decode(input logic [6:0] p, output int nib, output bit blk, output bit err);
        nib = 0;
        blk = 1'b0;
        err = 1'b1;
        if (p == 7'h7F) begin
            blk = 1'b1;
            err = 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (p == ref_pat[i]) begin
                    nib = i;
                    err = 1'b0;
                end
            end
        end
    endtask

    task automatic model_flush();
        q_nib.delete();
        q_blk.delete();
        q_err.delete();
    endtask

    // One clock: drive inputs, check outputs at negedge, advance the model at posedge
    task automatic step(input bit v, input logic [6:0] s, input bit wr, input bit clr, input bit rst);
        bit exp_ready;
        bit acc;
        bit hs;
        int nib;
        bit blk;
        bit err;
        seg_valid  = v;
        seg_in     = s;
        word_ready = wr;
        clear      = clr;
        reset      = rst;
        if (!rst) begin
            m_live = 1'b0;
            m_hold = 1'b0;
            model_flush();
        end
        @(negedge clk);
        if (m_hold) begin
`ifdef SEG7_BACKTOBACK_EN
            exp_ready = wr;
`else
            exp_ready = 1'b0;
`endif
        end else begin
            exp_ready = m_live;
        end
        obs_ready = seg_ready;
        chk("seg_ready", 32'(seg_ready), 32'(exp_ready));
        chk("word_valid", 32'(word_valid), 32'(m_hold));
        if (m_hold) begin
            chk("word_out", 32'(word_out), 32'(m_word));
            chk("blank_mask", 32'(blank_mask), 32'(m_blank));
            chk("err_mask", 32'(err_mask), 32'(m_err));
        end
        if (!rst) begin
            chk("rst_word", 32'(word_out), 32'd0);
            chk("rst_masks", 32'({blank_mask, err_mask}), 32'd0);
        end
        acc = v && exp_ready;
        hs  = m_hold && wr;
        ref_decode(s, nib, blk, err);
        @(posedge clk);
        if (rst) begin
            m_live = 1'b1;
            if (clr) begin
                m_hold = 1'b0;
                model_flush();
            end else begin
                if (hs) m_hold = 1'b0;
                if (acc) begin
                    q_nib.push_back(nib);
                    q_blk.push_back(blk);
                    q_err.push_back(err);
                    if (q_nib.size() == N) begin
                        m_word  = '0;
                        m_blank = '0;
                        m_err   = '0;
                        for (int i = 0; i < N; i++) begin
                            m_word  = (m_word * 16) + (4*N)'(q_nib[i]);
                            m_blank = (m_blank * 2) + N'(q_blk[i]);
                            m_err   = (m_err * 2) + N'(q_err[i]);
                        end
                        m_hold = 1'b1;
                        model_flush();
                    end
                end
            end
        end
        #1;
    endtask

    task automatic send_digits(input int d0, input int d1, input int d2,
                               input int d3, input int d4, input int d5, input bit wr);
        int d [6];
        d = '{d0, d1, d2, d3, d4, d5};
        for (int i = 0; i < 6; i++) step(1'b1, ref_pat[d[i]], wr, 1'b0, 1'b1);
    endtask

    function automatic logic [6:0] rand_seg();
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0) return 7'h7F;
        else if (r < 3) return 7'($urandom);
        else return ref_pat[$urandom_range(0, 15)];
    endfunction

    initial begin
        int sent;
        int idle;
        int exp_idle;
        m_live = 1'b0;
        m_hold = 1'b0;
        m_word = '0;
        m_blank = '0;
        m_err = '0;
        obs_ready = 1'b0;
        reset = 1'b0;
        clear = 1'b0;
        seg_valid = 1'b0;
        seg_in = 7'h00;
        word_ready = 1'b0;
        #1;
        step(1'b1, ref_pat[1], 1'b0, 1'b0, 1'b0);
        step(1'b1, ref_pat[2], 1'b0, 1'b0, 1'b0);
        step(1'b0, 7'h00, 1'b0, 1'b0, 1'b1);

        // 1..6 back to back, consumer ready
        send_digits(1, 2, 3, 4, 5, 6, 1'b1);
        chk("t1_valid", 32'(word_valid), 32'd1);
        chk("t1_word", 32'(word_out), 32'h123456);
        chk("t1_masks", 32'({blank_mask, err_mask}), 32'd0);
        step(1'b0, 7'h00, 1'b1, 1'b0, 1'b1);
        chk("t1_drop", 32'(word_valid), 32'd0);

        // A..F held while the consumer stalls; extra digits must be ignored
        send_digits(10, 11, 12, 13, 14, 15, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, ref_pat[i], 1'b0, 1'b0, 1'b1);
        chk("t2_word", 32'(word_out), 32'hABCDEF);
        step(1'b0, 7'h00, 1'b1, 1'b0, 1'b1);

        // 8, blank, 0, bad pattern, 9, F: blank is 2nd digit, error is 4th
        step(1'b1, ref_pat[8], 1'b0, 1'b0, 1'b1);
        step(1'b1, 7'b1111111, 1'b0, 1'b0, 1'b1);
        step(1'b1, ref_pat[0], 1'b0, 1'b0, 1'b1);
        step(1'b1, 7'b0101010, 1'b0, 1'b0, 1'b1);
        step(1'b1, ref_pat[9], 1'b0, 1'b0, 1'b1);
        step(1'b1, ref_pat[15], 1'b0, 1'b0, 1'b1);
        chk("t3_word", 32'(word_out), 32'h80009F);
        chk("t3_blank", 32'(blank_mask), 32'(6'b010000));
        chk("t3_err", 32'(err_mask), 32'(6'b000100));
        step(1'b0, 7'h00, 1'b1, 1'b0, 1'b1);

        // partial word flushed by clear
        for (int i = 0; i < 3; i++) step(1'b1, ref_pat[i + 7], 1'b0, 1'b0, 1'b1);
        step(1'b0, 7'h00, 1'b0, 1'b1, 1'b1);
        send_digits(6, 5, 4, 3, 2, 1, 1'b0);
        chk("t4_word", 32'(word_out), 32'h654321);
        step(1'b0, 7'h00, 1'b1, 1'b0, 1'b1);

        // partial word discarded by reset
        for (int i = 0; i < 3; i++) step(1'b1, ref_pat[i + 3], 1'b0, 1'b0, 1'b1);
        step(1'b0, 7'h00, 1'b0, 1'b0, 1'b0);
        step(1'b1, ref_pat[9], 1'b0, 1'b0, 1'b0);
        step(1'b0, 7'h00, 1'b0, 1'b0, 1'b1);
        send_digits(15, 14, 13, 0, 1, 2, 1'b0);
        chk("t5_word", 32'(word_out), 32'hFED012);
        step(1'b0, 7'h00, 1'b1, 1'b0, 1'b1);

        // 12 continuous digits with the consumer always ready
        sent = 0;
        idle = 0;
        for (int c = 0; c < 40 && sent < 12; c++) begin
            step(1'b1, ref_pat[sent], 1'b1, 1'b0, 1'b1);
            if (obs_ready) sent++;
            else idle++;
        end
`ifdef SEG7_BACKTOBACK_EN
        exp_idle = 0;
`else
        exp_idle = 1;
`endif
        chk("b2b_sent", 32'(sent), 32'd12);
        chk("b2b_idle", 32'(idle), 32'(exp_idle));

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 3) != 0), rand_seg(), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 49) == 0), ($urandom_range(0, 199) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
